// File: rtl/spike_packet_generator.sv
// -----------------------------------------------------------------------------
// spike_packet_generator
//
// Collects spike events from the neuron block during a time tick and queues
// each fired neuron's routing word in a first-word fall-through packet FIFO
// for the router. A small FSM (idle / active / drain) gates pushes to the
// tick window and signals when the tick is finished and every queued packet
// has been delivered.
//
// Optional feature: define SPG_DROP_COUNT_EN to build a saturating 16-bit
// counter of spikes discarded because the FIFO was full. Without it
// drop_count is tied to zero.
//
// Ports:
//   clk           single clock, rising edge
//   reset_n       asynchronous active-low reset
//   tick_start    pulse opening a time tick
//   spike_valid   strobe: spike_in / routing_info valid for current neuron
//   spike_in      current neuron fired this tick
//   routing_info  {dx[29:21], dy[20:12], dest_axon[11:4], delay[3:0]}
//   tick_done     pulse: last neuron of the tick evaluated
//   packet_ready  router accepts packet_data this cycle
//   packet_valid  packet_data holds a valid packet (FIFO not empty)
//   packet_data   FIFO head, bit-for-bit copy of the pushed routing_info
//   fifo_full     FIFO holds FIFO_DEPTH entries
//   fifo_empty    FIFO holds no entries
//   drained       pulse: tick complete and all packets delivered
//   drop_count    spikes dropped since reset (zero unless SPG_DROP_COUNT_EN)
// -----------------------------------------------------------------------------
module spike_packet_generator #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PTR_W      = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick_start,
  input  logic        spike_valid,
  input  logic        spike_in,
  input  logic [29:0] routing_info,
  input  logic        tick_done,
  input  logic        packet_ready,
  output logic        packet_valid,
  output logic [29:0] packet_data,
  output logic        fifo_full,
  output logic        fifo_empty,
  output logic        drained,
  output logic [15:0] drop_count
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDrain  = 2'd2
  } state_e;

  state_e           state_q;
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [29:0]      mem [FIFO_DEPTH];
  logic             push_req;
  logic             push;
  logic             pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty   = (wr_ptr_q == rd_ptr_q);
  assign fifo_full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign packet_valid = !fifo_empty;
  assign packet_data  = mem[rd_ptr_q[PTR_W-1:0]];

  assign pop      = packet_valid && packet_ready;
  assign push_req = (state_q == StActive) && spike_valid && spike_in;
  // A same-cycle pop frees a slot, so a full FIFO can still accept a push.
  assign push     = push_req && (!fifo_full || pop);

  // Pushes only happen in the active state, so an empty FIFO while draining
  // means nothing is left in flight.
  assign drained  = (state_q == StDrain) && fifo_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle:   if (tick_start) state_q <= StActive;
        StActive: if (tick_done)  state_q <= StDrain;
        StDrain:  if (fifo_empty) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
      if (pop)  rd_ptr_q <= rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Storage is deliberately not reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= routing_info;
  end

`ifdef SPG_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_count_q;

  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count_q <= 16'd0;
    end else if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule
